// File: rtl/alu_serial_ctrl_pkg.sv
// Shared definitions for the bit-serial ALU sequencer: alu_op and comp
// code constants, slice function field values, FSM state encoding and
// the SET-bit compare selector used when ALU_SERIAL_COMP_EN is defined.
package alu_serial_ctrl_pkg;

    // Full alu_op codes {A_invert, B_invert, operation[1:0]}
    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_NOR = 4'b1100;

    // operation[1:0] field as seen by the 1-bit slice
    localparam logic [1:0] FN_AND = 2'b00;
    localparam logic [1:0] FN_OR  = 2'b01;
    localparam logic [1:0] FN_ADD = 2'b10;
    localparam logic [1:0] FN_SET = 2'b11;

    // comp codes selecting the SET bit
    localparam logic [2:0] COMP_LT = 3'b000;
    localparam logic [2:0] COMP_GT = 3'b001;
    localparam logic [2:0] COMP_LE = 3'b010;
    localparam logic [2:0] COMP_GE = 3'b011;
    localparam logic [2:0] COMP_EQ = 3'b110;
    localparam logic [2:0] COMP_NE = 3'b100;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    // SET bit from the resolved less/equal pair; unknown codes give 0
    function automatic logic comp_set(input logic [2:0] c, input logic less, input logic equal);
        logic r;
        case (c)
            COMP_LT: r = less;
            COMP_GT: r = ~less & ~equal;
            COMP_LE: r = less | equal;
            COMP_GE: r = ~less;
            COMP_EQ: r = equal;
            COMP_NE: r = ~equal;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/alu_serial_ctrl_bit_slice.sv
// One-bit ALU slice: optional A/B inversion, then AND / OR / full-adder sum.
// The SET function returns 0 here; the raw sum bit is exported separately
// so the sequencer can resolve less/equal from it.
module alu_bit_slice
    import alu_serial_ctrl_pkg::*;
(
    input  logic       a_i,
    input  logic       b_i,
    input  logic       a_inv_i,
    input  logic       b_inv_i,
    input  logic [1:0] op_i,
    input  logic       cin_i,
    output logic       res_o,
    output logic       sum_o,
    output logic       cout_o
);

    logic a_eff;
    logic b_eff;

    // Inversion, full adder and function select
    always_comb begin
        a_eff  = a_i ^ a_inv_i;
        b_eff  = b_i ^ b_inv_i;
        sum_o  = a_eff ^ b_eff ^ cin_i;
        cout_o = (a_eff & b_eff) | (a_eff & cin_i) | (b_eff & cin_i);
        case (op_i)
            FN_AND:  res_o = a_eff & b_eff;
            FN_OR:   res_o = a_eff | b_eff;
            FN_ADD:  res_o = a_eff ^ b_eff ^ cin_i;
            default: res_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_serial_ctrl.sv
// Bit-serial ALU sequencer: runs alu_bit_slice over WIDTH cycles, LSB first.
// Optional feature macro: ALU_SERIAL_COMP_EN (SET bit chosen by captured comp).
module alu_serial_ctrl
    import alu_serial_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    input  logic [3:0]       alu_op,
    input  logic [2:0]       comp,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             cout,
    output logic             overflow
);

    localparam int unsigned   CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-2:0] sh_q;
    logic [3:0]       op_q;
    logic [2:0]       comp_q;
    logic [CW-1:0]    cnt_q;
    logic             carry_q;
    logic             nz_q;

    logic             s_res;
    logic             s_sum;
    logic             s_cout;

    logic [WIDTH-1:0] full_d;
    logic [WIDTH-1:0] result_d;
    logic             ovf_d;
    logic             cout_d;
    logic             less;
    logic             equal;
    logic             set_d;

    alu_bit_slice u_slice (
        .a_i     (a_q[0]),
        .b_i     (b_q[0]),
        .a_inv_i (op_q[3]),
        .b_inv_i (op_q[2]),
        .op_i    (op_q[1:0]),
        .cin_i   (carry_q),
        .res_o   (s_res),
        .sum_o   (s_sum),
        .cout_o  (s_cout)
    );

    // Final-bit resolution: the MSB slice outputs are folded straight into the
    // registered results so done/result/flags are valid in the FIN cycle itself
    always_comb begin
        full_d = {s_res, sh_q};
        ovf_d  = op_q[1] & (carry_q ^ s_cout);
        cout_d = op_q[1] & s_cout;
        less   = s_sum ^ carry_q ^ s_cout;
        equal  = ~(nz_q | s_sum);
`ifdef ALU_SERIAL_COMP_EN
        set_d  = comp_set(comp_q, less, equal);
`else
        set_d  = less;
`endif
        if (op_q[1:0] == FN_SET) begin
            result_d = {{(WIDTH-1){1'b0}}, set_d};
        end else begin
            result_d = full_d;
        end
    end

`ifndef ALU_SERIAL_COMP_EN
    // comp is captured but has no effect without the compare feature
    logic unused_cfg;
    always_comb unused_cfg = ^{comp_q, equal};
`endif

    // Sequencer: IDLE accepts, RUN shifts one bit per cycle, FIN holds done
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            sh_q     <= '0;
            op_q     <= '0;
            comp_q   <= '0;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            nz_q     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
            zero     <= 1'b0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        a_q     <= src1;
                        b_q     <= src2;
                        op_q    <= alu_op;
                        comp_q  <= comp;
                        cnt_q   <= '0;
                        carry_q <= alu_op[2];
                        nz_q    <= 1'b0;
                        busy    <= 1'b1;
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    a_q     <= a_q >> 1;
                    b_q     <= b_q >> 1;
                    sh_q    <= full_d[WIDTH-1:1];
                    carry_q <= s_cout;
                    nz_q    <= nz_q | s_sum;
                    cnt_q   <= cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        result   <= result_d;
                        zero     <= (result_d == '0);
                        cout     <= cout_d;
                        overflow <= ovf_d;
                        done     <= 1'b1;
                        state_q  <= S_FIN;
                    end
                end
                S_FIN: begin
                    busy    <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule
